// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: frame FSM states, Set-2
// prefix/discard byte values, ps2_key field positions and the byte
// classification helper used by the encoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_REL   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Keyboard status/reply bytes that never map to a key event.
  localparam logic [7:0] BYTE_ERR0   = 8'h00;
  localparam logic [7:0] BYTE_BAT_OK = 8'hAA;
  localparam logic [7:0] BYTE_ECHO   = 8'hEE;
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;
  localparam logic [7:0] BYTE_ERR1   = 8'hFF;

  localparam int unsigned KEY_TGL = 10;
  localparam int unsigned KEY_PRS = 9;
  localparam int unsigned KEY_EXT = 8;

  // Number of bytes swallowed after the 0xE1 that opens a Pause sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic is_discard(input logic [7:0] b);
    return (b == BYTE_ERR0)   || (b == BYTE_BAT_OK) || (b == BYTE_ECHO) ||
           (b == BYTE_ACK)    || (b == BYTE_RESEND) || (b == BYTE_ERR1);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter for one raw PS/2 line.
// The filtered output adopts a new level only after FILTER_LEN consecutive
// synchronized samples disagree with it; any shorter excursion is dropped.
//   clk_sys   : system clock
//   reset     : synchronous, active-high; filtered line returns to idle-high
//   line_raw  : asynchronous PS/2 pin
//   line_filt : synchronized, debounced level
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line_raw,
  output logic line_filt
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       filt_q,  filt_d;
  logic [7:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = line_raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == 8'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_filt = filt_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 Set-2 keyboard receiver producing the toggle-style ps2_key event word.
//   clk_sys    : system clock
//   reset      : synchronous, active-high
//   ps2_clk    : raw PS/2 clock pin (idle high)
//   ps2_data   : raw PS/2 data pin (idle high)
//   ps2_key    : {toggle, pressed, extended, code[7:0]}, held between events
//   key_strobe : one-cycle pulse in the cycle ps2_key changes
//   frame_err  : one-cycle pulse on parity/stop error or mid-frame timeout
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 96000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic clk_f, data_f, fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .line_raw  (ps2_clk),
    .line_filt (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .line_raw  (ps2_data),
    .line_filt (data_f)
  );

  ps2_state_e    state_q,    state_d;
  logic [2:0]    bit_idx_q,  bit_idx_d;
  logic [7:0]    shift_q,    shift_d;
  logic          parity_q,   parity_d;
  logic [TW-1:0] tmo_q,      tmo_d;
  logic          ext_q,      ext_d;
  logic          rel_q,      rel_d;
  logic [2:0]    ign_q,      ign_d;
  logic [10:0]   key_q,      key_d;
  logic          strobe_q,   strobe_d;
  logic          err_q,      err_d;
  logic          clk_prev_q, clk_prev_d;

  assign fall = clk_prev_q & ~clk_f;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    ext_d      = ext_q;
    rel_d      = rel_q;
    ign_d      = ign_q;
    key_d      = key_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    clk_prev_d = clk_f;

    if ((state_q == ST_IDLE) || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_f) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end
        ST_DATA: begin
          shift_d   = {data_f, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_f;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (data_f && (^{shift_q, parity_q})) begin
            // Byte is classified here so the key register loads on the
            // edge that closes the STOP-fall cycle.
            if (ign_q != '0) begin
              ign_d = ign_q - 3'd1;
            end else if (shift_q == PFX_PAUSE) begin
              ign_d = PAUSE_SKIP;
            end else if (shift_q == PFX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PFX_REL) begin
              rel_d = 1'b1;
            end else if (is_discard(shift_q)) begin
              ext_d = 1'b0;
              rel_d = 1'b0;
            end else begin
              key_d[KEY_TGL]  = ~key_q[KEY_TGL];
              key_d[KEY_PRS]  = ~rel_q;
              key_d[KEY_EXT]  = ext_q;
              key_d[7:0]      = shift_q;
              strobe_d        = 1'b1;
              ext_d           = 1'b0;
              rel_d           = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
            ign_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && (tmo_q == TMO_LAST)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
      ign_d   = '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      ext_q      <= 1'b0;
      rel_q      <= 1'b0;
      ign_q      <= '0;
      key_q      <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      ext_q      <= ext_d;
      rel_q      <= rel_d;
      ign_q      <= ign_d;
      key_q      <= key_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      clk_prev_q <= clk_prev_d;
    end
  end

  assign ps2_key    = key_q;
  assign key_strobe = strobe_q;
  assign frame_err  = err_q;

endmodule
